// File: rtl/lzw_pkg.sv
//------------------------------------------------------------------------------
// Module   : lzw_pkg
// Brief    : Shared constants and state encoding for the LZW code packer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lzw_pkg;

  localparam int CODE_W_DEFAULT = 12;
  localparam int BYTE_W         = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } packer_state_t;

endpackage : lzw_pkg

`default_nettype wire

// File: rtl/lzw_code_packer.sv
//------------------------------------------------------------------------------
// Module   : lzw_code_packer
// Brief    : Packs fixed-width codes MSB-first into a byte stream, with flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lzw_code_packer
  import lzw_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code_data,
  input  logic              flush,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              flush_done,
  output logic [CNT_W-1:0]  code_count,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int ACC_W = CODE_W + BYTE_W;
  localparam int CW    = $clog2(ACC_W + 1);

  localparam logic [CW-1:0] c_code_w = CW'(CODE_W);
  localparam logic [CW-1:0] c_byte_w = CW'(BYTE_W);
  localparam logic [CW-1:0] c_room   = CW'(ACC_W - CODE_W);

  logic [ACC_W-1:0]  r_acc;
  logic [CW-1:0]     r_cnt;
  packer_state_t     r_state;
  logic              r_flush_done;
  logic [CNT_W-1:0]  r_code_count;
  logic [CNT_W-1:0]  r_byte_count;

  logic              w_accept;
  logic              w_emit;
  logic              w_bv;
  logic [ACC_W-1:0]  w_acc_sh;
  logic [ACC_W-1:0]  w_code_al;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CW-1:0]     w_cnt_sh;
  logic [CW-1:0]     w_cnt_nxt;
  packer_state_t     w_state_nxt;
  logic              w_flush_done_nxt;

  // Ready looks only at registered state so byte_ready never reaches code_ready.
  assign code_ready = !rst && (r_state == RUN) && (r_cnt <= c_room);
  assign byte_valid = !rst && w_bv;
  assign byte_data  = r_acc[ACC_W-1 -: BYTE_W];
  assign byte_last  = !rst && (r_state == DRAIN) && (r_cnt != '0) && (r_cnt <= c_byte_w);
  assign flush_done = r_flush_done;
  assign code_count = r_code_count;
  assign byte_count = r_byte_count;

  assign w_accept = code_valid & code_ready;
  assign w_emit   = byte_valid & byte_ready;

  always_comb begin
    w_bv = 1'b0;
    if (r_state == RUN) w_bv = (r_cnt >= c_byte_w);
    else                w_bv = (r_cnt != '0);
  end

  // Emit first, then insert the new code directly below the remaining bits.
  always_comb begin
    w_acc_sh  = w_emit ? (r_acc << BYTE_W) : r_acc;
    w_cnt_sh  = r_cnt;
    if (w_emit) w_cnt_sh = (r_cnt >= c_byte_w) ? (r_cnt - c_byte_w) : '0;
    w_code_al = {code_data, {BYTE_W{1'b0}}} >> w_cnt_sh;
    w_acc_nxt = w_accept ? (w_acc_sh | w_code_al) : w_acc_sh;
    w_cnt_nxt = w_accept ? (w_cnt_sh + c_code_w) : w_cnt_sh;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      RUN: begin
        if (flush) begin
          if (w_cnt_nxt == '0) w_flush_done_nxt = 1'b1;
          else                 w_state_nxt      = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_cnt == '0) || (w_emit && (r_cnt <= c_byte_w))) begin
          w_state_nxt      = RUN;
          w_flush_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_state      <= RUN;
      r_flush_done <= 1'b0;
      r_code_count <= '0;
      r_byte_count <= '0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_done_nxt;
      if (w_accept) r_code_count <= r_code_count + CNT_W'(1);
      if (w_emit)   r_byte_count <= r_byte_count + CNT_W'(1);
    end
  end

endmodule : lzw_code_packer

`default_nettype wire

// File: tb/tb_lzw_code_packer.sv
//------------------------------------------------------------------------------
// Module   : tb_lzw_code_packer
// Brief    : Self-checking bench for lzw_code_packer against a bit-queue model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lzw_code_packer;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          code_valid = 1'b0;
  logic          code_ready;
  logic [CW-1:0] code_data = '0;
  logic          flush = 1'b0;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          flush_done;
  logic [31:0]   code_count;
  logic [31:0]   byte_count;

  lzw_code_packer #(.CODE_W(CW), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_data  (code_data),
    .flush      (flush),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .flush_done (flush_done),
    .code_count (code_count),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: the stream is a queue of bits; bytes take the oldest eight.
  bit          mq[$];
  bit          m_drain;
  bit          m_fd;
  logic [31:0] m_cc;
  logic [31:0] m_bc;
  logic [7:0]  got[$];

  logic       s_rdy, s_bv, s_bl, s_fd;
  logic [7:0] s_bd;

  typedef struct {
    logic          v;
    logic [CW-1:0] c;
    logic          f;
    logic          br;
    logic          e_rdy;
    logic          e_bv;
    logic [7:0]    e_bd;
    logic          e_bl;
    logic          e_fd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_drain = 1'b0;
    m_fd    = 1'b0;
    m_cc    = '0;
    m_bc    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; code_valid = 1'b0; flush = 1'b0; byte_ready = 1'b0;
    #1;
    chk("rdy_in_reset", {31'd0, code_ready}, 32'd0);
    model_clear();
  endtask

  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic f, input logic br);
    logic       e_rdy, e_bv, e_bl;
    logic [7:0] e_bd;
    bit         od;
    int         n;
    @(negedge clk);
    rst = 1'b0; code_valid = v; code_data = c; flush = f; byte_ready = br;
    #1;
    s_rdy = code_ready; s_bv = byte_valid; s_bd = byte_data; s_bl = byte_last; s_fd = flush_done;
    n     = mq.size();
    e_rdy = !m_drain && (n <= 8);
    e_bv  = m_drain ? (n >= 1) : (n >= 8);
    e_bl  = m_drain && (n >= 1) && (n <= 8);
    e_bd  = '0;
    for (int i = 0; i < 8; i++) if (i < n) e_bd[7-i] = mq[i];
    chk("code_ready", {31'd0, s_rdy}, {31'd0, e_rdy});
    chk("byte_valid", {31'd0, s_bv}, {31'd0, e_bv});
    chk("byte_last", {31'd0, s_bl}, {31'd0, e_bl});
    chk("flush_done", {31'd0, s_fd}, {31'd0, m_fd});
    if (e_bv) chk("byte_data", {24'd0, s_bd}, {24'd0, e_bd});
    chk("code_count", code_count, m_cc);
    chk("byte_count", byte_count, m_bc);
    m_fd = 1'b0;
    od   = m_drain;
    if (e_bv && br) begin
      got.push_back(s_bd);
      for (int i = 0; i < 8; i++) if (mq.size() > 0) void'(mq.pop_front());
      m_bc++;
    end
    if (v && e_rdy) begin
      for (int i = CW-1; i >= 0; i--) mq.push_back(c[i]);
      m_cc++;
    end
    if (od) begin
      if (e_bv && br && mq.size() == 0) begin
        m_drain = 1'b0;
        m_fd    = 1'b1;
      end
    end else if (f) begin
      if (mq.size() == 0) m_fd = 1'b1;
      else                m_drain = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] exp8[12];
    int         idx;
    int         guard;

    tbl[0]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 12'hDEF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 12'hDEF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 12'h123, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    exp8 = '{8'h00, 8'h10, 8'h02, 8'h00, 8'h30, 8'h04,
             8'h00, 8'h50, 8'h06, 8'h00, 8'h70, 8'h08};

    do_reset();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].f, tbl[i].br);
      chk($sformatf("tbl%0d_rdy", i), {31'd0, s_rdy}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_bv", i), {31'd0, s_bv}, {31'd0, tbl[i].e_bv});
      chk($sformatf("tbl%0d_bl", i), {31'd0, s_bl}, {31'd0, tbl[i].e_bl});
      chk($sformatf("tbl%0d_fd", i), {31'd0, s_fd}, {31'd0, tbl[i].e_fd});
      if (tbl[i].e_bv) chk($sformatf("tbl%0d_bd", i), {24'd0, s_bd}, {24'd0, tbl[i].e_bd});
    end
    chk("tbl_code_count", code_count, 32'd3);
    chk("tbl_byte_count", byte_count, 32'd5);

    // Eight back-to-back codes with byte_ready toggling.
    do_reset();
    got.delete();
    idx   = 0;
    guard = 0;
    while (got.size() < 12 && guard < 80) begin
      cycle(idx < 8, CW'(idx + 1), 1'b0, guard[0] == 1'b0);
      if (idx < 8 && s_rdy) idx++;
      guard++;
    end
    chk("toggle_byte_total", got.size(), 32'd12);
    for (int i = 0; i < 12; i++)
      if (i < got.size()) chk($sformatf("toggle_byte%0d", i), {24'd0, got[i]}, {24'd0, exp8[i]});
    chk("toggle_codes", code_count, 32'd8);

    // Backpressure: ready must fall once bits pile up, and recover after one emit.
    do_reset();
    cycle(1'b1, 12'hABC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 12'hABC, 1'b0, 1'b0);
      chk("bp_ready_low", {31'd0, s_rdy}, 32'd0);
    end
    cycle(1'b1, 12'hABC, 1'b0, 1'b1);
    chk("bp_emit_byte", {24'd0, s_bd}, 32'hAB);
    cycle(1'b1, 12'h5A5, 1'b0, 1'b0);
    chk("bp_ready_back", {31'd0, s_rdy}, 32'd1);

    // Reset mid-stream with 16 buffered bits.
    do_reset();
    cycle(1'b0, 12'h000, 1'b0, 1'b0);
    chk("rst_bv", {31'd0, s_bv}, 32'd0);
    chk("rst_code_count", code_count, 32'd0);
    chk("rst_byte_count", byte_count, 32'd0);
    cycle(1'b1, 12'hFFF, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    chk("rst_first_bv", {31'd0, s_bv}, 32'd1);
    chk("rst_first_byte", {24'd0, s_bd}, 32'hFF);
    cycle(1'b0, 12'h000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 12'h000, 1'b0, 1'b1);

    // Randomized traffic against the model, then a final drain.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, CW'($urandom), ($urandom % 40) == 0, ($urandom % 3) != 0);
    cycle(1'b0, 12'h000, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 12'h000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lzw_code_packer

`default_nettype wire
